// File: rtl/core_pkg.sv
// Shared core types used by the hazard controller: forwarding selects and
// the hazard FSM state encoding.
package core_pkg;
  localparam int CORE_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN,
    HZ_MEM_WAIT
  } hz_state_e;
endpackage

// File: rtl/fwd_unit.sv
// Per-operand EX forwarding select: EX/MEM result beats MEM/WB result,
// and x0 is never forwarded.
module fwd_unit
  import core_pkg::*;
#(
  parameter int AW = CORE_REG_AW
) (
  input  logic [AW-1:0] ex_rs_addr_i,
  input  logic [AW-1:0] mem_rd_addr_i,
  input  logic          mem_RegWrite_i,
  input  logic [AW-1:0] wb_rd_addr_i,
  input  logic          wb_RegWrite_i,
  output fwd_sel_e      sel_o
);
  always_comb begin
    sel_o = FWD_RF;
    if (mem_RegWrite_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == ex_rs_addr_i))
      sel_o = FWD_MEM;
    else if (wb_RegWrite_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == ex_rs_addr_i))
      sel_o = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage core.
// Optional perf counters (stall_cnt_o, flush_cnt_o) when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = CORE_REG_AW,
  parameter int MEM_TIMEOUT    = 255
`ifdef HAZ_PERF_CNT_EN
  ,parameter int CNT_WIDTH     = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_use_rs1_i,
  input  logic                      id_use_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_RegWrite_i,
  input  logic                      ex_MemRead_i,
  input  logic                      ex_redirect_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
  input  logic                      mem_RegWrite_i,
  input  logic                      mem_dreq_i,
  input  logic                      mem_dready_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic                      wb_RegWrite_i,
  output logic                      pc_stall_o,
  output logic                      if_id_stall_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_stall_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_stall_o,
  output logic                      mem_wb_flush_o,
  output logic [1:0]                fwd_a_sel_o,
  output logic [1:0]                fwd_b_sel_o,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o,
`endif
  output logic                      mem_timeout_o
);
  localparam int AW  = REG_ADDR_WIDTH;
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  logic mem_wait, load_use, ex_rd_ex_ok;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;

  // Operand forwarding, A = index 0, B = index 1
  logic [1:0][AW-1:0] ex_rs;
  fwd_sel_e [1:0]     fwd_sel;

  assign ex_rs[0] = ex_rs1_addr_i;
  assign ex_rs[1] = ex_rs2_addr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_unit #(.AW(AW)) u_fwd (
      .ex_rs_addr_i   (ex_rs[gi]),
      .mem_rd_addr_i  (mem_rd_addr_i),
      .mem_RegWrite_i (mem_RegWrite_i),
      .wb_rd_addr_i   (wb_rd_addr_i),
      .wb_RegWrite_i  (wb_RegWrite_i),
      .sel_o          (fwd_sel[gi])
    );
  end

  // Stall is 0-cycle: a request not ready this cycle already freezes the pipe
  assign mem_wait    = ((state_q == HZ_MEM_WAIT) || mem_dreq_i) && !mem_dready_i;
  assign ex_rd_ex_ok = ex_MemRead_i && (ex_rd_addr_i != '0);
  assign load_use    = ex_rd_ex_ok &&
                       ((id_use_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                        (id_use_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  assign pc_stall_o     = rst_n & pc_stall;
  assign if_id_stall_o  = rst_n & if_id_stall;
  assign if_id_flush_o  = rst_n & if_id_flush;
  assign id_ex_stall_o  = rst_n & id_ex_stall;
  assign id_ex_flush_o  = rst_n & id_ex_flush;
  assign ex_mem_stall_o = rst_n & ex_mem_stall;
  assign mem_wb_flush_o = rst_n & mem_wb_flush;
  assign fwd_a_sel_o    = rst_n ? fwd_sel[0] : FWD_RF;
  assign fwd_b_sel_o    = rst_n ? fwd_sel[1] : FWD_RF;
  assign mem_timeout_o  = timeout_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_dreq_i && !mem_dready_i) state_d = HZ_MEM_WAIT;
      end
      HZ_MEM_WAIT: begin
        if (mem_dready_i) begin
          state_d = HZ_RUN;
        end else begin
          wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
          if (TO_EN && (wait_cnt_q == WCW'(MEM_TIMEOUT - 1))) timeout_d = 1'b1;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pc_stall_o};
    flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, id_ex_flush_o};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4); checks perf
// counters too when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_rw, ex_mr, ex_redir, mem_rw, mem_dreq, mem_dready, wb_rw;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  logic [6:0] ctl;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_RD   = 7'b0010100;
  localparam logic [6:0] C_MW   = 7'b1101011;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2), .ex_rd_addr_i(ex_rd),
    .ex_RegWrite_i(ex_rw), .ex_MemRead_i(ex_mr), .ex_redirect_i(ex_redir),
    .mem_rd_addr_i(mem_rd), .mem_RegWrite_i(mem_rw),
    .mem_dreq_i(mem_dreq), .mem_dready_i(mem_dready),
    .wb_rd_addr_i(wb_rd), .wb_RegWrite_i(wb_rw),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
    .ex_mem_stall_o(ex_mem_stall), .mem_wb_flush_o(mem_wb_flush),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .mem_timeout_o(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, outputs checked 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_rw = 0; ex_mr = 0; ex_redir = 0;
    mem_rd = 0; mem_rw = 0; mem_dreq = 0; mem_dready = 0;
    wb_rd = 0; wb_rw = 0;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    // Reset gates outputs even with hazard and forwarding inputs active
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    mem_rw = 1; mem_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    tick(); tick();
    clr_inputs();
    rst_n = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    #1;
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    tick();

    // 1: load-use on rs1, one stall cycle then bubble clears it
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    chk("lu_rs1", 32'(ctl), 32'(C_LU));
    tick();
    ex_mr = 0; #1;
    chk("lu_after", 32'(ctl), 32'(C_IDLE));
`ifdef HAZ_PERF_CNT_EN
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_flush_cnt", flush_cnt, 32'd1);
`endif
    clr_inputs();
    ex_mr = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 7; #1;
    chk("lu_rs2", 32'(ctl), 32'(C_LU));
    id_use_rs2 = 0; #1;
    chk("lu_unused_rs", 32'(ctl), 32'(C_IDLE));
    ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
    chk("lu_x0", 32'(ctl), 32'(C_IDLE));
    ex_rd = 7; id_rs1 = 7; ex_mr = 0; ex_rw = 1; #1;
    chk("lu_not_load", 32'(ctl), 32'(C_IDLE));
    tick();

    // 2: redirect beats load-use
    clr_inputs();
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_redir = 1; #1;
    chk("redir_over_lu", 32'(ctl), 32'(C_RD));
    tick();
    clr_inputs(); #1;
    chk("redir_after", 32'(ctl), 32'(C_IDLE));

    // 3: forwarding priority and x0
    mem_rw = 1; mem_rd = 3; wb_rw = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 4; #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'd2);
    chk("fwd_b_none", 32'(fwd_b), 32'd0);
    mem_rw = 0; ex_rs2 = 3; #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'd1);
    chk("fwd_b_wb", 32'(fwd_b), 32'd1);
    mem_rw = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; #1;
    chk("fwd_a_x0", 32'(fwd_a), 32'd0);
    chk("fwd_b_x0", 32'(fwd_b), 32'd0);
    tick();

    // 4: three wait cycles, redirect ignored, forwarding live, ready releases
    clr_inputs();
    mem_dreq = 1; #1;
    chk("mw_c1", 32'(ctl), 32'(C_MW));
    tick();
    ex_redir = 1; mem_rw = 1; mem_rd = 9; ex_rs2 = 9; #1;
    chk("mw_c2_redir", 32'(ctl), 32'(C_MW));
    chk("mw_fwd_b", 32'(fwd_b), 32'd2);
    tick();
    ex_redir = 0; #1;
    chk("mw_c3", 32'(ctl), 32'(C_MW));
    tick();
    mem_dready = 1; #1;
    chk("mw_ready", 32'(ctl), 32'(C_IDLE));
    tick();
    clr_inputs(); #1;
    chk("mw_back_run", 32'(ctl), 32'(C_IDLE));
    chk("mw_no_timeout", 32'(mem_timeout), 32'd0);
    // Ready in the same cycle as request: no wait state
    mem_dreq = 1; mem_dready = 1; #1;
    chk("same_cyc_ready", 32'(ctl), 32'(C_IDLE));
    tick();
    clr_inputs(); #1;
    chk("same_cyc_after", 32'(ctl), 32'(C_IDLE));

    // 5: timeout sets after the 4th MEM_WAIT-state cycle and is sticky
    mem_dreq = 1;
    tick(); tick(); tick(); tick(); // now in 4th MEM_WAIT cycle
    chk("to_before", 32'(mem_timeout), 32'd0);
    tick();
    chk("to_set", 32'(mem_timeout), 32'd1);
    mem_dready = 1;
    tick();
    clr_inputs(); #1;
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_run_ctl", 32'(ctl), 32'(C_IDLE));
    tick();

    // 6: reset during MEM_WAIT
    mem_dreq = 1;
    tick(); tick();
    chk("rw_waiting", 32'(ctl), 32'(C_MW));
    rst_n = 1'b0; #1;
    chk("rw_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rw_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rw_stall_cnt", stall_cnt, 32'd0);
    chk("rw_flush_cnt", flush_cnt, 32'd0);
`endif
    clr_inputs();
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("rw_run_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rw_run_timeout", 32'(mem_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
